// File: rtl/nr_div_pkg.sv
// Shared types and sizing helpers for the sequential non-restoring divider.
package nr_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  // Iteration counter width for a given operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nr_addsub.sv
// Width-parameterised adder/subtractor: sub=1 computes a + ~b + 1.
module nr_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/nr_divider_seq.sv
// Sequential non-restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero and MIN/-1 overflow short-cuts straight to the result state.
module nr_divider_seq
  import nr_div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] qm_q, ym_q;
  logic [CW-1:0]    cnt_q;
  logic             sx_q, qneg_q;
  logic             in_ready_q, out_valid_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic             sgn_en, x_neg, y_neg, is_ovf;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   as_a, as_b, as_sum, rem_fix;
  logic             as_sub, as_cout;
  logic [WIDTH-1:0] rem_mag, q_res, r_res;

  assign sgn_en = SIGNED_EN && signed_mode;
  assign x_neg  = sgn_en & dividend[WIDTH-1];
  assign y_neg  = sgn_en & divisor[WIDTH-1];
  assign x_mag  = x_neg ? -dividend : dividend;
  assign y_mag  = y_neg ? -divisor : divisor;
  assign is_ovf = sgn_en && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

  // One adder serves both the per-bit step (CALC) and the final restore (FIX).
  assign as_a   = (state_q == CALC) ? {acc_q[WIDTH-1:0], qm_q[WIDTH-1]} : acc_q;
  assign as_b   = {1'b0, ym_q};
  assign as_sub = (state_q == CALC) ? ~acc_q[WIDTH] : 1'b0;

  nr_addsub #(.W(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum),
    .cout(as_cout)
  );

  assign rem_fix = acc_q[WIDTH] ? as_sum : acc_q;
  assign rem_mag = rem_fix[WIDTH-1:0];
  assign q_res   = qneg_q ? -qm_q : qm_q;
  assign r_res   = sx_q ? -rem_mag : rem_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      qm_q        <= '0;
      ym_q        <= '0;
      cnt_q       <= '0;
      sx_q        <= 1'b0;
      qneg_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          in_ready_q <= 1'b0;
          dbz_q      <= 1'b0;
          ovf_q      <= 1'b0;
          if (divisor == '0) begin
            quot_q      <= '1;
            rem_q       <= dividend;
            dbz_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (is_ovf) begin
            quot_q      <= dividend;
            rem_q       <= '0;
            ovf_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q   <= '0;
            qm_q    <= x_mag;
            ym_q    <= y_mag;
            cnt_q   <= '0;
            sx_q    <= x_neg;
            qneg_q  <= x_neg ^ y_neg;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= as_sum;
          qm_q  <= {qm_q[WIDTH-2:0], ~as_sum[WIDTH]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          quot_q      <= q_res;
          rem_q       <= r_res;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
